// File: rtl/rgb_frame_ram.sv
// Packed-pixel frame buffer: one masked write port, one pipelined read port
// (latency 1 or 2) with valid flag, and a sequential clear engine.
module rgb_frame_ram #(
  parameter int unsigned             CHANNELS    = 3,
  parameter int unsigned             BPC         = 6,
  parameter int unsigned             DEPTH       = 10000,
  parameter int unsigned             AW          = 16,
  parameter int unsigned             READ_LAT    = 1,
  parameter logic [CHANNELS*BPC-1:0] CLEAR_COLOR = '0,
  parameter logic [CHANNELS*BPC-1:0] OOR_COLOR   = '0,
  parameter string                   INIT_FILE   = ""
) (
  input  logic                    clkq,
  input  logic                    rstn,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [CHANNELS*BPC-1:0] wr_data,
  input  logic [CHANNELS-1:0]     wr_chmask,
  input  logic                    rd_en,
  input  logic [AW-1:0]           rd_addr,
  output logic [CHANNELS*BPC-1:0] rd_data,
  output logic                    rd_valid,
  input  logic                    clr_start,
  output logic                    clr_busy,
  output logic                    clr_done
);

  localparam int unsigned W  = CHANNELS * BPC;
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [IW-1:0] LAST    = IW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] clr_cnt;
  logic [W-1:0]  mem [DEPTH];

  logic          wr_ok;
  logic          rd_ok;
  logic [W-1:0]  rd_word;

  assign wr_ok   = wr_en && ({1'b0, wr_addr} < DEPTH_W) && (state != CLEAR);
  assign rd_ok   = {1'b0, rd_addr} < DEPTH_W;
  assign rd_word = rd_ok ? mem[rd_addr[IW-1:0]] : OOR_COLOR;

  // Storage has no reset; the clear engine owns the port while CLEAR is active.
  always_ff @(posedge clkq) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= CLEAR_COLOR;
    end else if (wr_ok) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (wr_chmask[i]) begin
          mem[wr_addr[IW-1:0]][i*BPC +: BPC] <= wr_data[i*BPC +: BPC];
        end
      end
    end
  end

  always_ff @(posedge clkq or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clr_done <= 1'b0;
          if (clr_start) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_cnt == LAST) begin
            state    <= DONE;
            clr_cnt  <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          clr_done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic         s1_valid;
      logic [W-1:0] s1_data;

      always_ff @(posedge clkq or negedge rstn) begin
        if (!rstn) begin
          s1_valid <= 1'b0;
          s1_data  <= '0;
          rd_valid <= 1'b0;
          rd_data  <= '0;
        end else begin
          s1_valid <= rd_en;
          if (rd_en) begin
            s1_data <= rd_word;
          end
          rd_valid <= s1_valid;
          if (s1_valid) begin
            rd_data <= s1_data;
          end
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clkq or negedge rstn) begin
        if (!rstn) begin
          rd_valid <= 1'b0;
          rd_data  <= '0;
        end else begin
          rd_valid <= rd_en;
          if (rd_en) begin
            rd_data <= rd_word;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_rgb_frame_ram.sv
// Directed bench for rgb_frame_ram: two instances (read latency 1 and 2) share
// one stimulus stream; expected words come from a hand-maintained shadow array.
module tb_rgb_frame_ram;

    localparam logic [17:0] CLR = 18'h1B2C3;
    localparam logic [17:0] OOR = 18'h30F0F;

    logic        clk = 1'b0;
    logic        rstn;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [17:0] wr_data;
    logic [2:0]  wr_chmask;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic        clr_start;

    logic [17:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;
    logic        busy_a, busy_b, done_a, done_b;

    logic [17:0] exp_mem [16];
    int          n_total = 0;
    int          n_bad   = 0;

    always #5 clk = ~clk;

    rgb_frame_ram #(
        .CHANNELS(3), .BPC(6), .DEPTH(16), .AW(5), .READ_LAT(1),
        .CLEAR_COLOR(CLR), .OOR_COLOR(OOR), .INIT_FILE("")
    ) u_lat1 (
        .clkq(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_chmask(wr_chmask), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .clr_start(clr_start), .clr_busy(busy_a), .clr_done(done_a)
    );

    rgb_frame_ram #(
        .CHANNELS(3), .BPC(6), .DEPTH(16), .AW(5), .READ_LAT(2),
        .CLEAR_COLOR(CLR), .OOR_COLOR(OOR), .INIT_FILE("")
    ) u_lat2 (
        .clkq(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_chmask(wr_chmask), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .clr_start(clr_start), .clr_busy(busy_b), .clr_done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [17:0] d, input logic [2:0] m);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_chmask = m;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [4:0] a, input logic [17:0] exp);
        @(negedge clk);
        rd_en = 1'b1; rd_addr = a;
        @(negedge clk);
        rd_en = 1'b0;
        check({tag, "_a_valid"}, 32'(rd_valid_a), 32'd1);
        check({tag, "_a_data"},  32'(rd_data_a),  32'(exp));
        check({tag, "_b_early"}, 32'(rd_valid_b), 32'd0);
        @(negedge clk);
        check({tag, "_a_drop"},  32'(rd_valid_a), 32'd0);
        check({tag, "_a_hold"},  32'(rd_data_a),  32'(exp));
        check({tag, "_b_valid"}, 32'(rd_valid_b), 32'd1);
        check({tag, "_b_data"},  32'(rd_data_b),  32'(exp));
    endtask

    // Back-to-back reads of every word against the shadow array.
    task automatic scan(input string tag);
        int va = 0;
        int vb = 0;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (rd_valid_a) va++;
            if (rd_valid_b) vb++;
            if (k >= 1 && k <= 16) check({tag, "_a"}, 32'(rd_data_a), 32'(exp_mem[k-1]));
            if (k >= 2) check({tag, "_b"}, 32'(rd_data_b), 32'(exp_mem[k-2]));
            rd_en   = (k < 16);
            rd_addr = 5'(k);
        end
        rd_en = 1'b0;
        check({tag, "_a_nvalid"}, 32'(va), 32'd16);
        check({tag, "_b_nvalid"}, 32'(vb), 32'd16);
    endtask

    task automatic clear_run(input string tag, input bit with_write, input bit poke);
        int nb_a = 0, nb_b = 0, nd_a = 0, nd_b = 0;
        @(negedge clk);
        clr_start = 1'b1;
        if (with_write) begin
            wr_en = 1'b1; wr_addr = 5'd2; wr_data = 18'h3FFFF; wr_chmask = 3'b111;
        end
        @(negedge clk);
        clr_start = 1'b0;
        wr_en     = 1'b0;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) @(negedge clk);
            if (busy_a) nb_a++;
            if (busy_b) nb_b++;
            if (done_a) nd_a++;
            if (done_b) nd_b++;
            if (poke && c == 4) begin
                wr_en = 1'b1; wr_addr = 5'd3; wr_data = 18'h12345; wr_chmask = 3'b111;
                clr_start = 1'b1;
            end else begin
                wr_en = 1'b0;
                clr_start = 1'b0;
            end
        end
        check({tag, "_busy_a"}, 32'(nb_a), 32'd16);
        check({tag, "_busy_b"}, 32'(nb_b), 32'd16);
        check({tag, "_done_a"}, 32'(nd_a), 32'd1);
        check({tag, "_done_b"}, 32'(nd_b), 32'd1);
        for (int i = 0; i < 16; i++) exp_mem[i] = CLR;
    endtask

    initial begin
        int nd;
        rstn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_chmask = '0;
        rd_en = 1'b0; rd_addr = '0; clr_start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd_data_a", 32'(rd_data_a), 32'd0);
        check("rst_rd_valid_a", 32'(rd_valid_a), 32'd0);
        check("rst_rd_data_b", 32'(rd_data_b), 32'd0);
        check("rst_rd_valid_b", 32'(rd_valid_b), 32'd0);
        check("rst_busy", 32'({busy_a, busy_b}), 32'd0);
        check("rst_done", 32'({done_a, done_b}), 32'd0);
        rstn = 1'b1;

        // Full clear; a write and a second clr_start while busy must be ignored.
        clear_run("clr1", 1'b0, 1'b1);

        wr(5'd5, {6'h3F, 6'h15, 6'h2A}, 3'b111);
        exp_mem[5] = {6'h3F, 6'h15, 6'h2A};
        read_chk("wr_full", 5'd5, {6'h3F, 6'h15, 6'h2A});

        wr(5'd5, {6'h11, 6'h07, 6'h22}, 3'b010);
        exp_mem[5] = {6'h3F, 6'h07, 6'h2A};
        read_chk("wr_mask_g", 5'd5, {6'h3F, 6'h07, 6'h2A});

        // Same-cycle read and write of address 9 returns the old word.
        wr(5'd9, 18'h00, 3'b111);
        @(negedge clk);
        rd_en = 1'b1; rd_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 18'h11; wr_chmask = 3'b111;
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0;
        check("rfw_a", 32'(rd_data_a), 32'h0);
        @(negedge clk);
        check("rfw_b", 32'(rd_data_b), 32'h0);
        exp_mem[9] = 18'h11;
        read_chk("rfw_next", 5'd9, 18'h11);

        wr(5'd6, 18'h00000, 3'b000);
        read_chk("oor_16", 5'd16, OOR);
        read_chk("oor_31", 5'd31, OOR);
        wr(5'd17, 18'h00000, 3'b111);
        wr(5'd31, 18'h2AAAA, 3'b111);
        scan("scan1");

        // Clear started together with a write: clear wins in the end.
        clear_run("clr2", 1'b1, 1'b0);
        scan("scan2");

        for (int i = 0; i < 16; i++) begin
            exp_mem[i] = 18'((i + 1) * 18'h00421);
            wr(5'(i), exp_mem[i], 3'b111);
        end

        // Reset after the clear engine has written words 0..7.
        @(negedge clk);
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        check("mid_busy", 32'({busy_a, busy_b}), 32'h3);
        repeat (8) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("mid_rd_data_a", 32'(rd_data_a), 32'd0);
        check("mid_rd_data_b", 32'(rd_data_b), 32'd0);
        check("mid_busy_off", 32'({busy_a, busy_b}), 32'd0);
        check("mid_valid", 32'({rd_valid_a, rd_valid_b}), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done_a || done_b || busy_a || busy_b) nd++;
        end
        check("mid_no_done", 32'(nd), 32'd0);
        for (int i = 0; i < 8; i++) exp_mem[i] = CLR;
        scan("scan3");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
